// File: rtl/storage_write_controller.sv
// rtl/storage_write_controller.sv - store-data byte parser, word FIFO and arbiter write handshake
// Bytes become {address, word} entries that drain one per ack to the memory arbiter.
module storage_write_controller #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_WIDTH = 19
) (
    input  logic                  i_master_clk,
    input  logic                  i_reset,
    input  logic                  i_storage_start,
    input  logic [7:0]            i_storage_data,
    input  logic                  i_storage_data_valid,
    output logic                  o_mem_request,
    input  logic                  i_mem_ack,
    output logic [ADDR_WIDTH-1:0] o_mem_address,
    output logic [15:0]           o_mem_data,
    output logic                  o_busy,
    output logic                  o_overflow
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    localparam logic [2:0] P_IDLE     = 3'd0;
    localparam logic [2:0] P_ADDR_HI  = 3'd1;
    localparam logic [2:0] P_ADDR_MID = 3'd2;
    localparam logic [2:0] P_ADDR_LO  = 3'd3;
    localparam logic [2:0] P_DATA_HI  = 3'd4;
    localparam logic [2:0] P_DATA_LO  = 3'd5;

    logic [2:0]            state;
    logic [ADDR_WIDTH-1:0] addr;
    logic [7:0]            held;

    logic [ADDR_WIDTH-1:0] fifo_addr [FIFO_DEPTH];
    logic [15:0]           fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;

    logic byte_in;
    logic push_req;
    logic not_empty;
    logic full;
    logic pop;
    logic push;
    logic drop;

    // A start in the same cycle as a byte always takes priority over the byte.
    assign byte_in   = i_storage_data_valid && !i_storage_start;
    assign push_req  = byte_in && (state == P_DATA_LO);
    assign not_empty = (count != '0);
    assign full      = (count == CNT_W'(FIFO_DEPTH));
    assign pop       = i_mem_ack && not_empty;
    assign push      = push_req && (!full || pop);
    assign drop      = push_req && full && !pop;

    always_ff @(posedge i_master_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= P_IDLE;
            addr  <= '0;
            held  <= '0;
        end else if (i_storage_start) begin
            state <= P_ADDR_HI;
            held  <= '0;
        end else if (byte_in) begin
            case (state)
                P_ADDR_HI: begin
                    addr  <= ADDR_WIDTH'({i_storage_data, 16'h0000});
                    state <= P_ADDR_MID;
                end
                P_ADDR_MID: begin
                    addr  <= addr | ADDR_WIDTH'({i_storage_data, 8'h00});
                    state <= P_ADDR_LO;
                end
                P_ADDR_LO: begin
                    addr  <= addr | ADDR_WIDTH'(i_storage_data);
                    state <= P_DATA_HI;
                end
                P_DATA_HI: begin
                    held  <= i_storage_data;
                    state <= P_DATA_LO;
                end
                P_DATA_LO: begin
                    // Address advances even when the word is dropped on a full FIFO.
                    addr  <= addr + ADDR_WIDTH'(1);
                    state <= P_DATA_HI;
                end
                default: state <= P_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_master_clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= addr;
            fifo_data[wr_ptr] <= {held, i_storage_data};
        end
    end

    always_ff @(posedge i_master_clk or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge i_master_clk or posedge i_reset) begin
        if (i_reset) begin
            o_overflow <= 1'b0;
        end else if (i_storage_start) begin
            o_overflow <= 1'b0;
        end else if (drop) begin
            o_overflow <= 1'b1;
        end
    end

    // Head outputs are forced to zero when empty so reset and idle states are defined.
    assign o_mem_request = not_empty;
    assign o_mem_address = not_empty ? fifo_addr[rd_ptr] : '0;
    assign o_mem_data    = not_empty ? fifo_data[rd_ptr] : '0;
    assign o_busy        = (state != P_IDLE) || not_empty;

endmodule

// File: tb/tb_storage_write_controller.sv
// tb/tb_storage_write_controller.sv - directed-vector bench for storage_write_controller
module tb_storage_write_controller;

    logic        i_master_clk;
    logic        i_reset;
    logic        i_storage_start;
    logic [7:0]  i_storage_data;
    logic        i_storage_data_valid;
    logic        o_mem_request;
    logic        i_mem_ack;
    logic [18:0] o_mem_address;
    logic [15:0] o_mem_data;
    logic        o_busy;
    logic        o_overflow;

    int n_checks = 0;
    int n_fail   = 0;

    storage_write_controller #(.FIFO_DEPTH(4), .ADDR_WIDTH(19)) dut (
        .i_master_clk         (i_master_clk),
        .i_reset              (i_reset),
        .i_storage_start      (i_storage_start),
        .i_storage_data       (i_storage_data),
        .i_storage_data_valid (i_storage_data_valid),
        .o_mem_request        (o_mem_request),
        .i_mem_ack            (i_mem_ack),
        .o_mem_address        (o_mem_address),
        .o_mem_data           (o_mem_data),
        .o_busy               (o_busy),
        .o_overflow           (o_overflow)
    );

    initial begin
        i_master_clk = 1'b0;
        forever #5 i_master_clk = ~i_master_clk;
    end

    task automatic do_reset();
        i_reset = 1'b1;
        i_storage_start = 1'b0;
        i_storage_data = 8'h00;
        i_storage_data_valid = 1'b0;
        i_mem_ack = 1'b0;
        repeat (2) @(posedge i_master_clk);
        #1 i_reset = 1'b0;
        @(posedge i_master_clk);
        #1;
    endtask

    task automatic send_start();
        i_storage_start = 1'b1;
        @(posedge i_master_clk);
        #1 i_storage_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        i_storage_data = b;
        i_storage_data_valid = 1'b1;
        @(posedge i_master_clk);
        #1 i_storage_data_valid = 1'b0;
    endtask

    task automatic pulse_ack();
        i_mem_ack = 1'b1;
        @(posedge i_master_clk);
        #1 i_mem_ack = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (o_mem_request !== 1'b0) begin n_fail++; $display("FAIL reset_req actual=%0h expected=0", o_mem_request); end
        n_checks++; if (o_mem_address !== 19'h0) begin n_fail++; $display("FAIL reset_addr actual=%0h expected=0", o_mem_address); end
        n_checks++; if (o_mem_data !== 16'h0) begin n_fail++; $display("FAIL reset_data actual=%0h expected=0", o_mem_data); end
        n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy actual=%0h expected=0", o_busy); end
        n_checks++; if (o_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf actual=%0h expected=0", o_overflow); end
        // ack with no request must be ignored
        pulse_ack();
        send_byte(8'h5A);
        n_checks++; if (o_mem_request !== 1'b0 || o_busy !== 1'b0) begin n_fail++; $display("FAIL idle_ignore actual=%0h/%0h expected=0/0", o_mem_request, o_busy); end
    endtask

    task automatic test_basic();
        do_reset();
        send_start();
        n_checks++; if (o_busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_start actual=%0h expected=1", o_busy); end
        send_byte(8'h01); send_byte(8'h23); send_byte(8'h45);
        send_byte(8'hAB);
        n_checks++; if (o_mem_request !== 1'b0) begin n_fail++; $display("FAIL basic_req_early actual=%0h expected=0", o_mem_request); end
        send_byte(8'hCD);
        n_checks++; if (o_mem_request !== 1'b1) begin n_fail++; $display("FAIL basic_req1 actual=%0h expected=1", o_mem_request); end
        n_checks++; if (o_mem_address !== 19'h12345) begin n_fail++; $display("FAIL basic_addr1 actual=%0h expected=12345", o_mem_address); end
        n_checks++; if (o_mem_data !== 16'hABCD) begin n_fail++; $display("FAIL basic_data1 actual=%0h expected=abcd", o_mem_data); end
        pulse_ack();
        n_checks++; if (o_mem_request !== 1'b0) begin n_fail++; $display("FAIL basic_req_drop1 actual=%0h expected=0", o_mem_request); end
        send_byte(8'h12); send_byte(8'h34);
        n_checks++; if (o_mem_address !== 19'h12346 || o_mem_data !== 16'h1234) begin n_fail++; $display("FAIL basic_word2 actual=%0h/%0h expected=12346/1234", o_mem_address, o_mem_data); end
        pulse_ack();
        n_checks++; if (o_mem_request !== 1'b0) begin n_fail++; $display("FAIL basic_req_drop2 actual=%0h expected=0", o_mem_request); end
        n_checks++; if (o_busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_parser actual=%0h expected=1", o_busy); end
    endtask

    task automatic test_wrap();
        do_reset();
        send_start();
        send_byte(8'h07); send_byte(8'hFF); send_byte(8'hFF);
        send_byte(8'h11); send_byte(8'h22);
        send_byte(8'h33); send_byte(8'h44);
        n_checks++; if (o_mem_address !== 19'h7FFFF || o_mem_data !== 16'h1122) begin n_fail++; $display("FAIL wrap_first actual=%0h/%0h expected=7ffff/1122", o_mem_address, o_mem_data); end
        pulse_ack();
        n_checks++; if (o_mem_request !== 1'b1 || o_mem_address !== 19'h00000 || o_mem_data !== 16'h3344) begin n_fail++; $display("FAIL wrap_second actual=%0h/%0h/%0h expected=1/0/3344", o_mem_request, o_mem_address, o_mem_data); end
        pulse_ack();
        n_checks++; if (o_mem_request !== 1'b0) begin n_fail++; $display("FAIL wrap_drain actual=%0h expected=0", o_mem_request); end
    endtask

    task automatic test_overflow();
        do_reset();
        send_start();
        send_byte(8'h00); send_byte(8'h01); send_byte(8'h00);
        for (int k = 0; k < 6; k++) begin
            send_byte(8'hA0 + 8'(k));
            send_byte(8'h50 + 8'(k));
            if (k == 3) begin
                n_checks++; if (o_overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_not_yet actual=%0h expected=0", o_overflow); end
            end
            if (k == 4) begin
                n_checks++; if (o_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set actual=%0h expected=1", o_overflow); end
            end
        end
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (o_mem_request !== 1'b1 || o_mem_address !== 19'h100 + 19'(k) || o_mem_data !== {8'hA0 + 8'(k), 8'h50 + 8'(k)}) begin
                n_fail++;
                $display("FAIL ovf_entry%0d actual=%0h/%0h/%0h expected=1/%0h/%0h", k, o_mem_request, o_mem_address, o_mem_data, 19'h100 + 19'(k), {8'hA0 + 8'(k), 8'h50 + 8'(k)});
            end
            pulse_ack();
        end
        n_checks++; if (o_mem_request !== 1'b0) begin n_fail++; $display("FAIL ovf_drained actual=%0h expected=0", o_mem_request); end
        n_checks++; if (o_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky actual=%0h expected=1", o_overflow); end
        send_start();
        n_checks++; if (o_overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear actual=%0h expected=0", o_overflow); end
    endtask

    task automatic test_full_push_pop();
        do_reset();
        send_start();
        send_byte(8'h00); send_byte(8'h02); send_byte(8'h00);
        for (int k = 0; k < 4; k++) begin
            send_byte(8'h10 + 8'(k));
            send_byte(8'h20 + 8'(k));
        end
        send_byte(8'h77);
        i_storage_data = 8'h88;
        i_storage_data_valid = 1'b1;
        i_mem_ack = 1'b1;
        @(posedge i_master_clk);
        #1 i_storage_data_valid = 1'b0;
        i_mem_ack = 1'b0;
        n_checks++; if (o_overflow !== 1'b0) begin n_fail++; $display("FAIL fpp_no_ovf actual=%0h expected=0", o_overflow); end
        n_checks++; if (o_mem_address !== 19'h201 || o_mem_data !== 16'h1121) begin n_fail++; $display("FAIL fpp_head actual=%0h/%0h expected=201/1121", o_mem_address, o_mem_data); end
        i_mem_ack = 1'b1;
        repeat (3) @(posedge i_master_clk);
        #1;
        n_checks++; if (o_mem_address !== 19'h204 || o_mem_data !== 16'h7788) begin n_fail++; $display("FAIL fpp_last actual=%0h/%0h expected=204/7788", o_mem_address, o_mem_data); end
        @(posedge i_master_clk);
        #1 i_mem_ack = 1'b0;
        n_checks++; if (o_mem_request !== 1'b0) begin n_fail++; $display("FAIL fpp_drain actual=%0h expected=0", o_mem_request); end
    endtask

    task automatic test_restart();
        do_reset();
        send_start();
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h05);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
        send_start();
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h10);
        send_byte(8'hBE); send_byte(8'hEF);
        n_checks++; if (o_mem_address !== 19'h00005 || o_mem_data !== 16'hAABB) begin n_fail++; $display("FAIL restart_first actual=%0h/%0h expected=5/aabb", o_mem_address, o_mem_data); end
        pulse_ack();
        n_checks++; if (o_mem_request !== 1'b1 || o_mem_address !== 19'h00010 || o_mem_data !== 16'hBEEF) begin n_fail++; $display("FAIL restart_second actual=%0h/%0h/%0h expected=1/10/beef", o_mem_request, o_mem_address, o_mem_data); end
        pulse_ack();
        n_checks++; if (o_mem_request !== 1'b0) begin n_fail++; $display("FAIL restart_drain actual=%0h expected=0", o_mem_request); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        send_start();
        send_byte(8'h00); send_byte(8'h03); send_byte(8'h00);
        send_byte(8'hC0); send_byte(8'h01);
        send_byte(8'hC0); send_byte(8'h02);
        send_byte(8'hC0); send_byte(8'h03);
        n_checks++; if (o_mem_address !== 19'h300 || o_mem_data !== 16'hC001) begin n_fail++; $display("FAIL b2b_head0 actual=%0h/%0h expected=300/c001", o_mem_address, o_mem_data); end
        i_mem_ack = 1'b1;
        @(posedge i_master_clk);
        #1;
        n_checks++; if (o_mem_request !== 1'b1 || o_mem_address !== 19'h301 || o_mem_data !== 16'hC002) begin n_fail++; $display("FAIL b2b_head1 actual=%0h/%0h/%0h expected=1/301/c002", o_mem_request, o_mem_address, o_mem_data); end
        @(posedge i_master_clk);
        #1;
        n_checks++; if (o_mem_request !== 1'b1 || o_mem_address !== 19'h302 || o_mem_data !== 16'hC003) begin n_fail++; $display("FAIL b2b_head2 actual=%0h/%0h/%0h expected=1/302/c003", o_mem_request, o_mem_address, o_mem_data); end
        @(posedge i_master_clk);
        #1;
        n_checks++; if (o_mem_request !== 1'b0) begin n_fail++; $display("FAIL b2b_drop actual=%0h expected=0", o_mem_request); end
        i_mem_ack = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        send_start();
        send_byte(8'h00); send_byte(8'h04); send_byte(8'h00);
        send_byte(8'h11); send_byte(8'h22);
        send_byte(8'h33);
        n_checks++; if (o_mem_request !== 1'b1) begin n_fail++; $display("FAIL rmid_pending actual=%0h expected=1", o_mem_request); end
        #2 i_reset = 1'b1;
        #1;
        n_checks++; if (o_mem_request !== 1'b0 || o_mem_address !== 19'h0 || o_mem_data !== 16'h0) begin n_fail++; $display("FAIL rmid_outputs actual=%0h/%0h/%0h expected=0/0/0", o_mem_request, o_mem_address, o_mem_data); end
        n_checks++; if (o_busy !== 1'b0 || o_overflow !== 1'b0) begin n_fail++; $display("FAIL rmid_status actual=%0h/%0h expected=0/0", o_busy, o_overflow); end
        @(posedge i_master_clk);
        #1 i_reset = 1'b0;
        send_byte(8'h44); send_byte(8'h55);
        n_checks++; if (o_mem_request !== 1'b0 || o_busy !== 1'b0) begin n_fail++; $display("FAIL rmid_ignore actual=%0h/%0h expected=0/0", o_mem_request, o_busy); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_overflow();
        test_full_push_pop();
        test_restart();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/storage_write_controller.md
# storage_write_controller

Sequences the byte stream produced by the SPI device controller for the store-data command into 16-bit word writes to video SRAM. Parses a 3-byte start word address, packs following bytes into words, buffers them in a small FIFO, and issues them one at a time through a request/acknowledge handshake to the shared memory arbiter. Sits between the device controller's storage outputs and the memory arbiter port it shares with playback.

## Interface

- FIFO_DEPTH, 4, word entries buffered (power of two, ≥2)
- ADDR_WIDTH, 19, word address width
- i_master_clk  in  1  master clock, all logic on rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_storage_start  in  1  one-cycle pulse: new store command begins
- i_storage_data  in  8  payload byte
- i_storage_data_valid  in  1  one-cycle byte strobe
- o_mem_request  out  1  write request to arbiter; held until acknowledged
- i_mem_ack  in  1  one-cycle pulse: head entry written
- o_mem_address  out  ADDR_WIDTH  word address of head entry
- o_mem_data  out  16  data of head entry
- o_busy  out  1  parser not idle or FIFO non-empty
- o_overflow  out  1  sticky: a word was dropped on full FIFO

One clock; reset is asynchronous and active-high.

## Operation

- Parser FSM: P_IDLE, P_ADDR_HI, P_ADDR_MID, P_ADDR_LO, P_DATA_HI, P_DATA_LO.
- i_storage_start (any state) -> P_ADDR_HI; discards pending half-word; clears o_overflow. Start and data_valid same cycle: start wins, byte ignored.
- P_IDLE: data bytes ignored.
- P_ADDR_HI: byte[2:0] -> addr[18:16] (bits 7:3 ignored) -> P_ADDR_MID; byte -> addr[15:8] -> P_ADDR_LO; byte -> addr[7:0] -> P_DATA_HI.
- P_DATA_HI: byte -> held high byte -> P_DATA_LO.
- P_DATA_LO: byte forms word {held, byte}; push {addr, word}; addr <= addr+1 mod 2^19 (0x7FFFF wraps to 0x00000); -> P_DATA_HI.
- Parser stays in data states until next start or reset; an odd trailing byte is never written.
- FIFO: FIFO_DEPTH entries of {address, data}. Push on full with no pop in same cycle: word dropped, o_overflow <= 1, address still increments. Push and pop same cycle on full: both accepted.
- Entries already queued are never flushed by a new start; they drain in order.
- Write side: o_mem_request = FIFO non-empty (from registered count); o_mem_address/o_mem_data = head entry, stable while request high. i_mem_ack with request high pops head; i_mem_ack with request low ignored.
- o_busy = (parser ≠ P_IDLE) or FIFO non-empty.

## Timing

- Reset: parser P_IDLE, FIFO empty, address 0, o_mem_request 0, o_mem_address 0, o_mem_data 0, o_busy 0, o_overflow 0.
- Low data byte sampled at edge E -> FIFO written at E -> o_mem_request high in cycle after E (latency 1).
- Ack sampled at edge A: if more entries, request stays high and next head presented in cycle after A (back-to-back, no bubble); else request low after A.
- Throughput: one word per ack cycle; input bytes may arrive every cycle.
- o_overflow sets the cycle after the dropping edge; clears the cycle after the start edge.
- Reset asserted mid-operation: all state cleared immediately, including an outstanding request; arbiter must drop it.

## Test plan

- Start, bytes 0x01,0x23,0x45,0xAB,0xCD,0x12,0x34, ack one cycle after each request -> writes (0x12345,0xABCD), (0x12346,0x1234); o_busy stays 1 (parser in P_DATA_HI).
- Address 0x07,0xFF,0xFF then 4 data bytes -> writes at 0x7FFFF then 0x00000.
- No acks, 6 words streamed with FIFO_DEPTH=4 -> 4 entries held, o_overflow=1; then ack 4 times -> addresses base..base+3 in order, request low; next start clears o_overflow.
- Start, address, 3 data bytes, new start, address 0x00,0x00,0x10, 2 bytes 0xBE,0xEF -> only first word and (0x00010,0xBEEF) written; odd byte dropped.
- Ack held high continuously with 3 queued words -> three writes on consecutive cycles, request drops after third.
- Assert i_reset while request pending and parser in P_DATA_LO -> all outputs 0 immediately; subsequent data bytes without start ignored.
